// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - shared types and constants for the QSPI line-fill path
package qspi_pkg;

    localparam int QSPI_ADDR_W     = 24;
    localparam int QSPI_LINE_WORDS = 8;
    // Byte offset within a 16-byte line; shared with the QSPI read front-end
    localparam int LINE_OFS_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA,
        ST_DONE,
        ST_ABORT
    } fill_state_t;

endpackage

// File: rtl/qspi_fill_timer.sv
// rtl/qspi_fill_timer.sv - stall counter with terminal-count flag for SDRAM waits
module qspi_fill_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic sd_clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    // Saturates at TIMEOUT so a held count cannot wrap back below the limit
    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/qspi_line_fill_ctrl.sv
// rtl/qspi_line_fill_ctrl.sv - fetches 16-byte QSPI lines from SDRAM into the line RAM
module qspi_line_fill_ctrl
    import qspi_pkg::*;
#(
    parameter int ADDR_W     = QSPI_ADDR_W,
    parameter int DATA_W     = 16,
    parameter int LINE_WORDS = QSPI_LINE_WORDS,
    parameter int TIMEOUT    = 255
) (
    input  logic                          sd_clk,
    input  logic                          rst,
    input  logic                          qspi_rd_req,
    input  logic [ADDR_W-1:0]             qspi_rd_addr,
    output logic                          qspi_rd_busy,
    output logic                          fill_done,
    output logic                          line_valid,
    output logic [ADDR_W-1:0]             line_tag,
    output logic                          sdr_rd_req,
    output logic [ADDR_W-1:0]             sdr_rd_addr,
    input  logic                          sdr_rd_ack,
    input  logic                          sdr_rd_valid,
    input  logic [DATA_W-1:0]             sdr_rd_data,
    output logic                          ram_wen,
    output logic [$clog2(LINE_WORDS)-1:0] ram_waddr,
    output logic [DATA_W-1:0]             ram_wdata,
    output logic                          err,
    input  logic                          err_clr
);

    localparam int WI_W = $clog2(LINE_WORDS);

    fill_state_t       state, state_nx;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] pend_addr;
    logic              pend_vld;
    logic [WI_W-1:0]   word_cnt;

    logic              in_fill, beat, last_beat, hit, dup, servicing, pend_wr;
    logic              next_vld, tmr_expired;
    logic [ADDR_W-1:0] next_addr;

    assign in_fill   = (state == ST_REQ) || (state == ST_DATA);
    assign servicing = (state == ST_DONE) || (state == ST_ABORT);
    assign beat      = (state == ST_DATA) && sdr_rd_valid;
    assign last_beat = beat && (word_cnt == WI_W'(LINE_WORDS - 1));

    // Line addresses are 16-byte aligned, so only the line-number bits matter
    assign hit = line_valid &&
                 (qspi_rd_addr[ADDR_W-1:LINE_OFS_W] == line_tag[ADDR_W-1:LINE_OFS_W]);
    assign dup = (qspi_rd_addr[ADDR_W-1:LINE_OFS_W] == cur_addr[ADDR_W-1:LINE_OFS_W]);

    assign pend_wr   = qspi_rd_req && in_fill && !dup;
    // A request landing in DONE/ABORT beats the older pending entry
    assign next_vld  = qspi_rd_req || pend_vld;
    assign next_addr = qspi_rd_req ? qspi_rd_addr : pend_addr;

    qspi_fill_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .sd_clk  (sd_clk),
        .rst     (rst),
        .clr     (!in_fill || (state == ST_REQ && sdr_rd_ack) || beat),
        .inc     (in_fill),
        .expired (tmr_expired)
    );

    always_comb begin
        state_nx     = state;
        qspi_rd_busy = (state != ST_IDLE);
        fill_done    = (state == ST_DONE);
        sdr_rd_req   = (state == ST_REQ);
        sdr_rd_addr  = (state == ST_REQ) ? cur_addr : '0;
        ram_wen      = beat;
        ram_waddr    = beat ? word_cnt : '0;
        ram_wdata    = beat ? sdr_rd_data : '0;
        case (state)
            ST_IDLE: begin
                if (qspi_rd_req && !hit) state_nx = ST_REQ;
            end
            ST_REQ: begin
                if (sdr_rd_ack)       state_nx = ST_DATA;
                else if (tmr_expired) state_nx = ST_ABORT;
            end
            ST_DATA: begin
                if (beat) begin
                    if (last_beat) state_nx = ST_DONE;
                end else if (tmr_expired) begin
                    state_nx = ST_ABORT;
                end
            end
            ST_DONE, ST_ABORT: begin
                state_nx = next_vld ? ST_REQ : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cur_addr   <= '0;
            pend_addr  <= '0;
            pend_vld   <= 1'b0;
            word_cnt   <= '0;
            line_valid <= 1'b0;
            line_tag   <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (qspi_rd_req && !hit) begin
                        cur_addr   <= qspi_rd_addr;
                        line_valid <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (sdr_rd_ack) word_cnt <= '0;
                end
                ST_DATA: begin
                    if (beat) word_cnt <= word_cnt + 1'b1;
                end
                ST_DONE: begin
                    line_valid <= 1'b1;
                    line_tag   <= cur_addr;
                end
                ST_ABORT: begin
                    line_valid <= 1'b0;
                end
                default: ;
            endcase

            if (servicing) begin
                pend_vld <= 1'b0;
                if (next_vld) cur_addr <= next_addr;
            end else if (pend_wr) begin
                pend_addr <= qspi_rd_addr;
                pend_vld  <= 1'b1;
            end

            if (state == ST_ABORT) err <= 1'b1;
            else if (err_clr)      err <= 1'b0;
        end
    end

endmodule
